uart_rx: RTL and testbench

UART receive stage: deserialises an asynchronous 8N1-style serial line into parallel bytes, using the single-cycle bit tick from the UART baud tick generator. It sits directly downstream of that generator. It drives the generator's enable on a start-bit falling edge, so the generator's half-period preload places the first tick at mid-start-bit and each later tick at mid-bit. Received bytes and error flags go to the host-side logic.

---
 rtl/uart_rx_if.sv | 36 +++
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/tick sources and the UART receive stage.
// The master side drives the line and bit tick; the slave side is the receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 tick;
  logic                 baud_enable;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx,
    output tick,
    input  baud_enable,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  tick,
    output baud_enable,
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive stage: samples an asynchronous serial line at baud-generator ticks
// and delivers each frame as a parallel word with framing and parity status.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int             CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_BITS - 1);
  localparam logic           PAR_EN   = (PARITY_EN != 0);
  localparam logic           PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit,
                                           input logic                 odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

  logic                 rx_meta_r;
  logic                 rxs_r;
  logic                 arm_r;
  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 parity_err_r;
  logic                 busy_r;

  logic [DATA_BITS-1:0] rx_data_s;
  logic                 rx_valid_s;
  logic                 frame_err_s;
  logic                 parity_err_s;
  logic                 busy_s;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Frame-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ticks only matter once a frame is in progress.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rxs_r && arm_r) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bus.tick) begin
          state_s = rxs_r ? IDLE : DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bus.tick && (cnt_r == CNT_LAST)) begin
          state_s = PAR_EN ? PARITY : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bus.tick) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bus.tick) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Arm flag, bit counter, LSB-first shift register and parity verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_r     <= 1'b1;
      cnt_r     <= '0;
      shift_r   <= '0;
      par_err_r <= 1'b0;
    end else begin
      // Arm only re-sets on a high line in IDLE, so a held break cannot retrigger.
      if (state_r == IDLE) begin
        if (state_s == START) begin
          arm_r <= 1'b0;
        end else if (rxs_r) begin
          arm_r <= 1'b1;
        end else begin
          arm_r <= arm_r;
        end
      end else begin
        arm_r <= arm_r;
      end

      case (state_r)
        START: begin
          if (bus.tick && !rxs_r) begin
            cnt_r     <= '0;
            par_err_r <= 1'b0;
          end
        end
        DATA: begin
          if (bus.tick) begin
            shift_r <= {rxs_r, shift_r[DATA_BITS-1:1]};
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        PARITY: begin
          if (bus.tick) begin
            par_err_r <= parity_mismatch(shift_r, rxs_r, PAR_ODD);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next values of the registered outputs; results are latched at the stop-bit tick.
  always_comb begin
    rx_data_s    = rx_data_r;
    rx_valid_s   = 1'b0;
    frame_err_s  = frame_err_r;
    parity_err_s = parity_err_r;
    busy_s       = (state_s != IDLE);
    if ((state_r == STOP) && bus.tick) begin
      rx_data_s    = shift_r;
      rx_valid_s   = 1'b1;
      frame_err_s  = ~rxs_r;
      parity_err_s = PAR_EN ? par_err_r : 1'b0;
    end else begin
      rx_valid_s   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_data_r    <= rx_data_s;
      rx_valid_r   <= rx_valid_s;
      frame_err_r  <= frame_err_s;
      parity_err_r <= parity_err_s;
      busy_r       <= busy_s;
    end
  end

  // The tick generator runs exactly while a frame is in progress.
  assign bus.baud_enable = busy_r;
  assign bus.busy        = busy_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.parity_err  = parity_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an even-parity instance, each fed by a
// tick model (period 101, first tick 51 cycles after enable) and a frame scoreboard.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) ifa ();
  uart_rx_if #(.DATA_BITS(8)) ifb ();

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t held[2];
  int   busy_cnt[2];
  int   valid_cnt[2];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   tc_a = 0;
  int   tc_b = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  // Baud generator model: counter restarts whenever the receiver drops its enable.
  always @(posedge clk) begin
    #1;
    if (rst || !ifa.baud_enable) begin
      tc_a = 0; ifa.tick = 1'b0;
    end else begin
      tc_a = tc_a + 1;
      ifa.tick = (tc_a >= 52) && (((tc_a - 52) % 101) == 0);
    end
    if (rst || !ifb.baud_enable) begin
      tc_b = 0; ifb.tick = 1'b0;
    end else begin
      tc_b = tc_b + 1;
      ifb.tick = (tc_b >= 52) && (((tc_b - 52) % 101) == 0);
    end
  end

  task automatic chk_inst(input int i, input logic valid, input logic [7:0] data,
                          input logic ferr, input logic perr, input logic busy, input logic be);
    string nm;
    exp_t  e;
    nm = (i == 0) ? "a" : "b";
    if (busy) busy_cnt[i]++;
    check({nm, "_busy_vs_baud_enable"}, busy, be);
    if (rst) begin
      held[i] = '0;
      check({nm, "_rst_valid"}, valid, 0);
      check({nm, "_rst_data"}, data, 0);
      check({nm, "_rst_flags"}, {ferr, perr, busy}, 0);
    end else if (valid) begin
      valid_cnt[i]++;
      e = held[i];
      if (i == 0 && q_a.size() > 0) e = q_a.pop_front();
      else if (i == 1 && q_b.size() > 0) e = q_b.pop_front();
      else check({nm, "_unexpected_valid"}, valid, 0);
      held[i] = e;
      check({nm, "_frame_data"}, data, e.data);
      check({nm, "_frame_ferr"}, ferr, e.ferr);
      check({nm, "_frame_perr"}, perr, e.perr);
      check({nm, "_busy_at_valid"}, busy, 0);
    end else begin
      check({nm, "_held_data"}, data, held[i].data);
      check({nm, "_held_flags"}, {ferr, perr}, {held[i].ferr, held[i].perr});
    end
  endtask

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    chk_inst(0, ifa.rx_valid, ifa.rx_data, ifa.frame_err, ifa.parity_err, ifa.busy, ifa.baud_enable);
    chk_inst(1, ifb.rx_valid, ifb.rx_data, ifb.frame_err, ifb.parity_err, ifb.busy, ifb.baud_enable);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int i, input logic b);
    if (i == 0) ifa.rx = b;
    else ifb.rx = b;
  endtask

  task automatic send_bit(input int i, input logic b);
    set_rx(i, b);
    idle(101);
  endtask

  task automatic send_frame(input int i, input logic [7:0] data, input logic has_par,
                            input logic pbit, input logic stop);
    exp_t e;
    e.data = data;
    e.ferr = ~stop;
    e.perr = has_par ? (((^data) ^ pbit) != 1'b0) : 1'b0;
    if (i == 0) q_a.push_back(e);
    else q_b.push_back(e);
    send_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(i, data[k]);
    if (has_par) send_bit(i, pbit);
    send_bit(i, stop);
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while (((i == 0) ? q_a.size() : q_b.size()) > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(i == 0 ? "a_drain_timeout" : "b_drain_timeout", (i == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    int v0;
    ifa.rx = 1'b1; ifb.rx = 1'b1; ifa.tick = 1'b0; ifb.tick = 1'b0;
    held[0] = '0; held[1] = '0;
    busy_cnt[0] = 0; busy_cnt[1] = 0; valid_cnt[0] = 0; valid_cnt[1] = 0;
    idle(3);
    check("reset_data", ifa.rx_data, 8'h00);
    check("reset_busy_be", {ifa.busy, ifa.baud_enable, ifa.rx_valid}, 3'b000);
    rst = 1'b0;
    idle(20);

    // Nominal 0xA5
    v0 = valid_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("a5_data", ifa.rx_data, 8'hA5);
    check("a5_ferr", ifa.frame_err, 1'b0);
    check("a5_valid_pulses", valid_cnt[0] - v0, 1);
    check("a5_baud_enable_low", ifa.baud_enable, 1'b0);

    // Back-to-back 0x00 then 0xFF
    v0 = valid_cnt[0];
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("b2b_valid_pulses", valid_cnt[0] - v0, 2);
    check("b2b_last_data", ifa.rx_data, 8'hFF);

    // False start: 20 low cycles, START is left at the first tick
    idle(50);
    v0 = valid_cnt[0];
    busy_cnt[0] = 0;
    set_rx(0, 1'b0);
    idle(20);
    set_rx(0, 1'b1);
    idle(300);
    check("false_start_busy_about_50", (busy_cnt[0] >= 48) && (busy_cnt[0] <= 56), 1'b1);
    check("false_start_no_valid", valid_cnt[0] - v0, 0);

    // Framing error then a 2000-cycle break
    v0 = valid_cnt[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_drain(0);
    check("ferr_data", ifa.rx_data, 8'h3C);
    check("ferr_flag", ifa.frame_err, 1'b1);
    busy_cnt[0] = 0;
    idle(2000);
    check("break_no_restart", busy_cnt[0], 0);
    check("break_single_valid", valid_cnt[0] - v0, 1);
    set_rx(0, 1'b1);
    idle(300);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("after_break_data", ifa.rx_data, 8'h5A);
    check("after_break_ferr", ifa.frame_err, 1'b0);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain(1);
    check("par_ok_data", ifb.rx_data, 8'h07);
    check("par_ok_flag", ifb.parity_err, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain(1);
    check("par_bad_flag", ifb.parity_err, 1'b1);

    // Reset after three data ticks with the line held low
    idle(50);
    set_rx(0, 1'b0);
    idle(380);
    check("mid_frame_busy", ifa.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_now_outputs", {ifa.busy, ifa.baud_enable, ifa.rx_valid, ifa.frame_err, ifa.parity_err}, 5'b0);
    check("rst_now_data", ifa.rx_data, 8'h00);
    set_rx(0, 1'b1);
    idle(5);
    rst = 1'b0;
    v0 = valid_cnt[0];
    busy_cnt[0] = 0;
    idle(1000);
    check("post_rst_no_valid", valid_cnt[0] - v0, 0);
    check("post_rst_idle", busy_cnt[0], 0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("post_rst_frame", ifa.rx_data, 8'hC3);

    idle(20);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
